bictr_dcnto_mode: RTL and testbench
===================================

Name: bictr_dcnto_mode

Overview:
Parametrised up/down counter with dynamic count-to compare and selectable terminal-count action: free-run, auto-reload, one-shot halt, or ping-pong between the load value and count_to. It adds a registered terminal pulse, a sticky terminal flag and a saturating terminal-event counter. It is used as the programmable timer/sequencer primitive in datapath control and symbol-timing blocks.

Parameters:
WIDTH, 13, counter/data/count_to width
EVT_WIDTH, 8, terminal-event counter width (saturating)
RST_VAL, 0, count value after reset (WIDTH bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-high
data  input  WIDTH  load value; also lower endpoint in ping-pong mode
count_to  input  WIDTH  dynamic terminal compare value
up_dn  input  1  1 = count up, 0 = count down (direction captured on load for ping-pong)
load  input  1  synchronous load, active-low
cen  input  1  count enable, active-high
mode  input  2  00 free-run, 01 auto-reload, 10 one-shot, 11 ping-pong
clr_evt  input  1  synchronous clear of flag and evt_cnt
count  output  WIDTH  current count (registered)
tercnt  output  1  combinational: count == count_to
ter_pulse  output  1  registered one-cycle pulse, one clock after a hit
flag  output  1  sticky, set by hit
evt_cnt  output  EVT_WIDTH  saturating number of hits
dir  output  1  effective direction (1 = up)
halted  output  1  1 while the one-shot is halted

Behaviour:
- Reset (async, high) drives count=RST_VAL, dir=1, halted=0, ter_pulse=0, flag=0, evt_cnt=0 and dir0=1; tercnt follows the compare immediately.
- step(x) = x+1 if dir=1, else x-1; arithmetic is modulo 2^WIDTH and wraps silently.
- hit = load & cen & ~halted & (count==count_to).
- Priority on each rising edge:
  - load=0: count<=data, dir<=up_dn, dir0<=up_dn, halted<=0. cen is ignored and no hit is generated.
  - Else, cen=0: everything holds.
  - Else, act per mode.
- Mode 00: count<=step(count); dir follows up_dn each cycle; a hit only flags.
- Mode 01: on hit, count<=data; otherwise count<=step(count); dir follows up_dn.
- Mode 10 (2-state FSM RUN/HALT):
  - RUN: step; on hit, count holds and the FSM goes to HALT with halted=1.
  - HALT: count frozen, tercnt stays 1, no further hits.
  - HALT exits only on load=0, or on mode leaving 10 (back to RUN next edge, count unchanged).
- Mode 11: dir is the internal register.
  - count==count_to: dir<=~dir0, count<=step in ~dir0 (counts as a hit).
  - Else if count==data and dir==~dir0: dir<=dir0, count<=step in dir0 (not a hit).
  - Else: count<=step(count).
  - data==count_to: the count_to rule wins; the counter then runs modulo and must not lock up.
  - Entering mode 11 without a load uses dir0 = last up_dn sampled while mode!=11.
- While mode!=11, dir0<=up_dn every cycle.
- ter_pulse<=hit.
- flag: set on hit, cleared by clr_evt; if both occur in the same cycle, flag=1.
- evt_cnt: increments on hit and saturates at 2^EVT_WIDTH-1. clr_evt alone sets 0; clr_evt together with hit sets 1.
- mode changes take effect on the next edge. count_to changes affect tercnt combinationally in the same cycle.
- Reset asserted mid-operation returns everything to reset values asynchronously; the first count occurs on the first edge after reset deasserts with cen=1.

Test Plan:
- WIDTH=4, mode 00, up, load data=14, cen=1 -> count 14,15,0,1; tercnt high only when count==count_to=0; evt_cnt=1.
- Mode 01, data=3, count_to=6, up -> 3,4,5,6,3,4…; ter_pulse one cycle after each 6; after 300 hits with EVT_WIDTH=8, evt_cnt=255.
- Mode 10, down, data=5, count_to=2 -> 5,4,3,2 then frozen at 2, halted=1, tercnt=1; load=0 with data=5 -> restarts at 5, halted=0.
- Mode 11, data=2, count_to=5, up -> 2,3,4,5,4,3,2,3,4,5…; dir toggles at 5 and 2; a hit occurs only at 5.
- load=0 and cen=1 with count==count_to -> data loaded, no hit, flag unchanged; clr_evt together with a hit -> flag=1, evt_cnt=1.
- Assert reset mid-count in mode 11 with RST_VAL=7 -> count=7, dir=1, flag=0 immediately without a clock; resumes up-counting after release.

Source files
------------

// File: rtl/bictr_dcnto_mode.sv
// Up/down counter with dynamic count-to compare and selectable terminal action
// (free-run, auto-reload, one-shot halt, ping-pong between data and count_to).
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous reset, active-high
//   data      load value; lower endpoint in ping-pong mode
//   count_to  dynamic terminal compare value
//   up_dn     1 = up, 0 = down
//   load      synchronous load, active-low (beats cen)
//   cen       count enable
//   mode      00 free-run, 01 auto-reload, 10 one-shot, 11 ping-pong
//   clr_evt   synchronous clear of flag and evt_cnt
//   count     registered count
//   tercnt    combinational count == count_to
//   ter_pulse registered one-cycle pulse one clock after a hit
//   flag      sticky hit flag
//   evt_cnt   saturating hit counter
//   dir       effective direction (1 = up)
//   halted    one-shot halted
module bictr_dcnto_mode #(
  parameter int WIDTH = 13,
  parameter int EVT_WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data,
  input  logic [WIDTH-1:0]     count_to,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic                 cen,
  input  logic [1:0]           mode,
  input  logic                 clr_evt,
  output logic [WIDTH-1:0]     count,
  output logic                 tercnt,
  output logic                 ter_pulse,
  output logic                 flag,
  output logic [EVT_WIDTH-1:0] evt_cnt,
  output logic                 dir,
  output logic                 halted
);

  localparam logic [WIDTH-1:0]     ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [EVT_WIDTH-1:0] EONE = {{(EVT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [EVT_WIDTH-1:0] EMAX = '1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } st_e;

  st_e state_q, state_d;

  logic [WIDTH-1:0]     count_q, count_d;
  logic                 dir_q, dir_d;
  logic                 dir0_q, dir0_d;
  logic                 pulse_q;
  logic                 flag_q, flag_d;
  logic [EVT_WIDTH-1:0] evt_q, evt_d;
  logic                 halt_s;
  logic                 hit;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] x,
    input logic             up
  );
    return up ? x + ONE : x - ONE;
  endfunction

  assign tercnt = (count_q == count_to);
  assign hit    = load & cen & ~halt_s & tercnt;

  // One-shot FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // One-shot FSM: next state
  always_comb begin
    state_d = state_q;
    if (!load) begin
      state_d = RUN;
    end else if (cen) begin
      unique case (state_q)
        RUN:  if (mode == 2'b10 && tercnt) state_d = HALT;
        HALT: if (mode != 2'b10) state_d = RUN;
      endcase
    end
  end

  // One-shot FSM: outputs
  always_comb begin
    halt_s = (state_q == HALT);
  end

  // Count / direction datapath
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    // dir0 tracks up_dn outside ping-pong so entering it
    // without a load starts in the last requested direction.
    dir0_d  = (mode != 2'b11) ? up_dn : dir0_q;
    if (!load) begin
      count_d = data;
      dir_d   = up_dn;
      dir0_d  = up_dn;
    end else if (cen && !halt_s) begin
      unique case (mode)
        2'b00: begin
          count_d = step(count_q, up_dn);
          dir_d   = up_dn;
        end
        2'b01: begin
          count_d = hit ? data : step(count_q, up_dn);
          dir_d   = up_dn;
        end
        2'b10: begin
          count_d = hit ? count_q : step(count_q, up_dn);
          dir_d   = up_dn;
        end
        2'b11: begin
          // count_to turn-around wins when data == count_to
          if (tercnt) begin
            dir_d   = ~dir0_q;
            count_d = step(count_q, ~dir0_q);
          end else if (count_q == data && dir_q != dir0_q) begin
            dir_d   = dir0_q;
            count_d = step(count_q, dir0_q);
          end else begin
            count_d = step(count_q, dir_q);
          end
        end
      endcase
    end
  end

  // Event bookkeeping: a hit beats clr_evt
  always_comb begin
    flag_d = hit | (flag_q & ~clr_evt);
    evt_d  = evt_q;
    if (clr_evt)
      evt_d = hit ? EONE : '0;
    else if (hit && evt_q != EMAX)
      evt_d = evt_q + EONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_VAL;
      dir_q   <= 1'b1;
      dir0_q  <= 1'b1;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      dir0_q  <= dir0_d;
      pulse_q <= hit;
      flag_q  <= flag_d;
      evt_q   <= evt_d;
    end
  end

  assign count     = count_q;
  assign ter_pulse = pulse_q;
  assign flag      = flag_q;
  assign evt_cnt   = evt_q;
  assign dir       = dir_q;
  assign halted    = halt_s;

endmodule

// File: tb/tb_bictr_dcnto_mode.sv
// Self-checking bench for bictr_dcnto_mode (WIDTH=4, RST_VAL=7):
// directed scenarios plus random stimulus against a behavioural model.
module tb_bictr_dcnto_mode;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data, count_to;
  logic       up_dn, load, cen, clr_evt;
  logic [1:0] mode;
  logic [3:0] count;
  logic       tercnt, ter_pulse, flag, dir, halted;
  logic [7:0] evt_cnt;

  int total = 0;
  int bad = 0;

  // behavioural model state
  int m_cnt, m_evt;
  bit m_dir, m_dir0, m_halt, m_pulse, m_flag;

  bictr_dcnto_mode #(
    .WIDTH(4), .EVT_WIDTH(8), .RST_VAL(4'd7)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .count_to(count_to),
    .up_dn(up_dn), .load(load), .cen(cen), .mode(mode),
    .clr_evt(clr_evt), .count(count), .tercnt(tercnt),
    .ter_pulse(ter_pulse), .flag(flag), .evt_cnt(evt_cnt),
    .dir(dir), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap(input int x);
    return ((x % 16) + 16) % 16;
  endfunction

  // Applies one rising edge to the model using the current inputs.
  task automatic model_edge();
    bit hit, nd, nd0, nh;
    int nc;
    hit = load && cen && !m_halt && (m_cnt == int'(count_to));
    nc = m_cnt;
    nd = m_dir;
    nd0 = (mode != 2'd3) ? up_dn : m_dir0;
    nh = m_halt;
    if (!load) begin
      nc = data; nd = up_dn; nd0 = up_dn; nh = 0;
    end else if (cen && m_halt) begin
      nh = (mode == 2'd2);
    end else if (cen) begin
      case (mode)
        2'd0: begin nc = wrap(m_cnt + (up_dn ? 1 : -1)); nd = up_dn; end
        2'd1: begin
          nc = hit ? int'(data) : wrap(m_cnt + (up_dn ? 1 : -1));
          nd = up_dn;
        end
        2'd2: begin
          if (hit) nh = 1;
          else nc = wrap(m_cnt + (up_dn ? 1 : -1));
          nd = up_dn;
        end
        default: begin
          if (m_cnt == int'(count_to)) begin
            nd = !m_dir0; nc = wrap(m_cnt + (!m_dir0 ? 1 : -1));
          end else if (m_cnt == int'(data) && m_dir != m_dir0) begin
            nd = m_dir0; nc = wrap(m_cnt + (m_dir0 ? 1 : -1));
          end else begin
            nc = wrap(m_cnt + (m_dir ? 1 : -1));
          end
        end
      endcase
    end
    if (clr_evt) m_evt = hit ? 1 : 0;
    else if (hit && m_evt < 255) m_evt = m_evt + 1;
    m_flag = hit ? 1'b1 : (clr_evt ? 1'b0 : m_flag);
    m_pulse = hit;
    m_cnt = nc; m_dir = nd; m_dir0 = nd0; m_halt = nh;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load = 1'b1; cen = 1'b0; clr_evt = 1'b0; mode = 2'd0;
    up_dn = 1'b1; data = 4'd0; count_to = 4'd3;
    #8;
    total++;
    if ({count, dir, halted, ter_pulse, flag, evt_cnt} !== {4'd7, 4'b1000, 8'd0}) begin
      bad++;
      $display("FAIL reset: cnt=%0d dir=%b h=%b p=%b f=%b evt=%0d want 7 1 0 0 0 0",
               count, dir, halted, ter_pulse, flag, evt_cnt);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_free_run();
    logic [3:0] ec [3] = '{4'd15, 4'd0, 4'd1};
    logic       et [3] = '{1'b0, 1'b1, 1'b0};
    mode = 2'd0; up_dn = 1'b1; data = 4'd14; count_to = 4'd0;
    cen = 1'b1; load = 1'b0; clr_evt = 1'b1;
    tick();
    load = 1'b1; clr_evt = 1'b0;
    total++;
    if (count !== 4'd14 || tercnt !== 1'b0) begin
      bad++;
      $display("FAIL free_load: cnt=%0d tc=%b want 14 0", count, tercnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (count !== ec[i] || tercnt !== et[i]) begin
        bad++;
        $display("FAIL free_run[%0d]: cnt=%0d tc=%b want %0d %b",
                 i, count, tercnt, ec[i], et[i]);
      end
    end
    total++;
    if (evt_cnt !== 8'd1) begin
      bad++;
      $display("FAIL free_evt: evt=%0d want 1", evt_cnt);
    end
  endtask

  task automatic test_reload();
    logic [3:0] ec [5] = '{4'd4, 4'd5, 4'd6, 4'd3, 4'd4};
    logic       ep [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 2'd1; up_dn = 1'b1; data = 4'd3; count_to = 4'd6;
    load = 1'b0; clr_evt = 1'b1;
    tick();
    load = 1'b1; clr_evt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (count !== ec[i] || ter_pulse !== ep[i]) begin
        bad++;
        $display("FAIL reload[%0d]: cnt=%0d pulse=%b want %0d %b",
                 i, count, ter_pulse, ec[i], ep[i]);
      end
    end
    repeat (1200) tick();
    total++;
    if (evt_cnt !== 8'd255 || flag !== 1'b1) begin
      bad++;
      $display("FAIL reload_sat: evt=%0d flag=%b want 255 1", evt_cnt, flag);
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] ec [5] = '{4'd4, 4'd3, 4'd2, 4'd2, 4'd2};
    logic       eh [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ep [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 2'd2; up_dn = 1'b0; data = 4'd5; count_to = 4'd2;
    load = 1'b0;
    tick();
    load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (count !== ec[i] || halted !== eh[i] || ter_pulse !== ep[i]) begin
        bad++;
        $display("FAIL oneshot[%0d]: cnt=%0d h=%b p=%b want %0d %b %b",
                 i, count, halted, ter_pulse, ec[i], eh[i], ep[i]);
      end
    end
    total++;
    if (tercnt !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_tc: tc=%b want 1", tercnt);
    end
    load = 1'b0;
    tick();
    load = 1'b1;
    total++;
    if (count !== 4'd5 || halted !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_reload: cnt=%0d h=%b want 5 0", count, halted);
    end
  endtask

  task automatic test_pingpong();
    logic [3:0] ec [10] = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd3,
                            4'd2, 4'd3, 4'd4, 4'd5, 4'd4};
    logic       ed [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    mode = 2'd3; up_dn = 1'b1; data = 4'd2; count_to = 4'd5;
    load = 1'b0; clr_evt = 1'b1;
    tick();
    load = 1'b1; clr_evt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (count !== ec[i] || dir !== ed[i]) begin
        bad++;
        $display("FAIL pingpong[%0d]: cnt=%0d dir=%b want %0d %b",
                 i, count, dir, ec[i], ed[i]);
      end
    end
    total++;
    if (evt_cnt !== 8'd2) begin
      bad++;
      $display("FAIL pingpong_hits: evt=%0d want 2", evt_cnt);
    end
  endtask

  task automatic test_load_priority();
    mode = 2'd0; up_dn = 1'b1; data = 4'd6; count_to = 4'd6;
    load = 1'b0; clr_evt = 1'b1;
    tick();
    clr_evt = 1'b0; data = 4'd9;
    tick();
    total++;
    if ({count, flag, ter_pulse, evt_cnt} !== {4'd9, 2'b00, 8'd0}) begin
      bad++;
      $display("FAIL load_nohit: cnt=%0d f=%b p=%b evt=%0d want 9 0 0 0",
               count, flag, ter_pulse, evt_cnt);
    end
    count_to = 4'd9;
    #1;
    total++;
    if (tercnt !== 1'b1) begin
      bad++;
      $display("FAIL tc_comb: tc=%b want 1", tercnt);
    end
    load = 1'b1; clr_evt = 1'b1;
    tick();
    clr_evt = 1'b0;
    total++;
    if ({count, flag, ter_pulse, evt_cnt} !== {4'd10, 2'b11, 8'd1}) begin
      bad++;
      $display("FAIL clr_hit: cnt=%0d f=%b p=%b evt=%0d want 10 1 1 1",
               count, flag, ter_pulse, evt_cnt);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'd3; up_dn = 1'b1; data = 4'd2; count_to = 4'd5;
    load = 1'b0;
    tick();
    load = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({count, dir, flag, evt_cnt, halted} !== {4'd7, 2'b10, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_rst: cnt=%0d dir=%b f=%b evt=%0d want 7 1 0 0",
               count, dir, flag, evt_cnt);
    end
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (count !== 4'd9 || dir !== 1'b1) begin
      bad++;
      $display("FAIL post_rst: cnt=%0d dir=%b want 9 1", count, dir);
    end
  endtask

  task automatic test_random();
    reset = 1'b1;
    #1 reset = 1'b0;
    m_cnt = 7; m_dir = 1; m_dir0 = 1; m_halt = 0;
    m_pulse = 0; m_flag = 0; m_evt = 0;
    for (int i = 0; i < 4000; i++) begin
      load = ($urandom_range(9) != 0);
      cen = ($urandom_range(7) != 0);
      clr_evt = ($urandom_range(19) == 0);
      if ($urandom_range(23) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) up_dn = ~up_dn;
      if ($urandom_range(15) == 0) data = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) count_to = 4'($urandom_range(15));
      model_edge();
      tick();
      total++;
      if ({count, dir, halted, ter_pulse, flag, evt_cnt, tercnt} !==
          {4'(m_cnt), m_dir, m_halt, m_pulse, m_flag, 8'(m_evt),
           (m_cnt == int'(count_to))}) begin
        bad++;
        $display("FAIL random[%0d]: cnt=%0d dir=%b h=%b p=%b f=%b evt=%0d tc=%b want %0d %b %b %b %b %0d %b",
                 i, count, dir, halted, ter_pulse, flag, evt_cnt, tercnt,
                 m_cnt, m_dir, m_halt, m_pulse, m_flag, m_evt,
                 (m_cnt == int'(count_to)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_reload();
    test_oneshot();
    test_pingpong();
    test_load_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
